dll_lock_ctrl: RTL and testbench

DLL_LOCK_CTRL -- requirements
Module: dll_lock_ctrl

---
 rtl/dll_pkg.sv | 25 ++
 rtl/dll_code_sat.sv | 45 ++++
 rtl/dll_lock_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dll_lock_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared types and constants for the DLL lock controller: FSM state encoding
// and the dll_mode output values.
package dll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_BYPASS  = 3'd3,
        ST_FAULT   = 3'd4
    } dll_state_t;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_BYPASS = 2'b01;
    localparam logic [1:0] MODE_RST    = 2'b10;

    function automatic logic [1:0] mode_of(input dll_state_t st);
        case (st)
            ST_LOCKED: return MODE_NORMAL;
            ST_BYPASS: return MODE_BYPASS;
            default:   return MODE_RST;
        endcase
    endfunction

endpackage

// File: rtl/dll_code_sat.sv
// Saturating delay-code stepper; flags a request that pushes past a rail
// the code already sits on.
module dll_code_sat #(
    parameter int CODE_W = 6
) (
    input  logic [CODE_W-1:0] code,
    input  logic [CODE_W-1:0] step,
    input  logic              up,
    input  logic              dn,
    output logic [CODE_W-1:0] code_nxt,
    output logic              at_rail_push
);

    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MIN = {CODE_W{1'b0}};

    logic [CODE_W:0] sum_s;

    // Only a lone up or a lone down is a step; both or neither leaves the code alone.
    always_comb begin
        code_nxt     = code;
        at_rail_push = 1'b0;
        sum_s        = {1'b0, code} + {1'b0, step};
        if (up && !dn) begin
            if (code == CODE_MAX) begin
                at_rail_push = 1'b1;
            end else if (sum_s > {1'b0, CODE_MAX}) begin
                code_nxt = CODE_MAX;
            end else begin
                code_nxt = sum_s[CODE_W-1:0];
            end
        end else if (dn && !up) begin
            if (code == CODE_MIN) begin
                at_rail_push = 1'b1;
            end else if (code < step) begin
                code_nxt = CODE_MIN;
            end else begin
                code_nxt = code - step;
            end
        end else begin
            code_nxt = code;
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// DLL lock controller: coarse acquisition, fine tracking once reversals show
// the loop is dithering, with rail-saturation and watchdog fault supervision.
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int NPHASE      = 32,
    parameter int CODE_W      = 6,
    parameter int STEP_ACQ    = 4,
    parameter int LOCK_REV    = 8,
    parameter int UNLOCK_RUN  = 16,
    parameter int TIMEOUT     = 1024,
    parameter int WARN_MARGIN = 2
) (
    input  logic                      CKINP,
    input  logic                      RESET,
    input  logic                      en,
    input  logic                      bypass,
    input  logic                      pd_valid,
    input  logic                      pd_up,
    input  logic                      pd_dn,
    input  logic [$clog2(NPHASE)-1:0] phase_sel,
    output logic [CODE_W-1:0]         dly_code,
    output logic [1:0]                dll_mode,
    output logic                      locked,
    output logic                      warning,
    output logic                      fault,
    output logic [NPHASE-1:0]         phase_oh
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int REV_W = $clog2(LOCK_REV + 1);
    localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

    localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] WARN_LO   = CODE_W'(WARN_MARGIN);
    localparam logic [CODE_W-1:0] WARN_HI   = CODE_MAX - CODE_W'(WARN_MARGIN);
    localparam logic [CODE_W-1:0] STEP_FINE = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CODE_W-1:0] STEP_CRS  = CODE_W'(STEP_ACQ);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [REV_W-1:0]  REV_DONE  = REV_W'(LOCK_REV);
    localparam logic [REV_W-1:0]  REV_ONE   = REV_W'(1);
    localparam logic [RUN_W-1:0]  RUN_DONE  = RUN_W'(UNLOCK_RUN);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [NPHASE-1:0] TAP0      = {{(NPHASE-1){1'b0}}, 1'b1};

    dll_state_t         state_r;
    dll_state_t         state_nxt_s;
    logic [WD_W-1:0]    wd_cnt_r;
    logic [REV_W-1:0]   rev_cnt_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic               have_dir_r;
    logic               last_dn_r;

    logic [CODE_W-1:0]  step_size_s;
    logic [CODE_W-1:0]  sat_code_s;
    logic [CODE_W-1:0]  code_nxt_s;
    logic               rail_push_s;
    logic               loop_on_s;
    logic               in_loop_nxt_s;
    logic               step_s;
    logic               step_dn_s;
    logic               move_s;
    logic               reversal_s;
    logic               rail_fault_s;
    logic               wd_expire_s;
    logic               unlock_s;
    logic [RUN_W-1:0]   run_nxt_s;

    function automatic logic warn_of(input logic [CODE_W-1:0] code);
        return (code < WARN_LO) || (code > WARN_HI);
    endfunction

    dll_code_sat #(.CODE_W(CODE_W)) u_code_sat (
        .code         (dly_code),
        .step         (step_size_s),
        .up           (pd_up),
        .dn           (pd_dn),
        .code_nxt     (sat_code_s),
        .at_rail_push (rail_push_s)
    );

    // Step qualification and lock/unlock/fault conditions.
    always_comb begin
        step_size_s  = (state_r == ST_LOCKED) ? STEP_FINE : STEP_CRS;
        loop_on_s    = ((state_r == ST_ACQUIRE) || (state_r == ST_LOCKED)) && en && !bypass;
        step_s       = pd_up ^ pd_dn;
        step_dn_s    = pd_dn & ~pd_up;
        move_s       = loop_on_s && pd_valid && step_s && !rail_push_s;
        rail_fault_s = loop_on_s && pd_valid && step_s && rail_push_s;
        reversal_s   = move_s && have_dir_r && (step_dn_s != last_dn_r);
        wd_expire_s  = loop_on_s && !pd_valid && (wd_cnt_r == WD_LAST);
        run_nxt_s    = (have_dir_r && (step_dn_s == last_dn_r)) ? (run_cnt_r + RUN_ONE) : RUN_ONE;
        unlock_s     = (state_r == ST_LOCKED) && move_s && (run_nxt_s == RUN_DONE);
    end

    // Next-state selection; bypass outranks every other request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bypass)  state_nxt_s = ST_BYPASS;
                else if (en) state_nxt_s = ST_ACQUIRE;
                else         state_nxt_s = ST_IDLE;
            end
            ST_ACQUIRE: begin
                if (bypass)                      state_nxt_s = ST_BYPASS;
                else if (!en)                    state_nxt_s = ST_IDLE;
                else if (rail_fault_s)           state_nxt_s = ST_FAULT;
                else if (wd_expire_s)            state_nxt_s = ST_FAULT;
                else if (rev_cnt_r == REV_DONE)  state_nxt_s = ST_LOCKED;
                else                             state_nxt_s = ST_ACQUIRE;
            end
            ST_LOCKED: begin
                if (bypass)            state_nxt_s = ST_BYPASS;
                else if (!en)          state_nxt_s = ST_IDLE;
                else if (rail_fault_s) state_nxt_s = ST_FAULT;
                else if (wd_expire_s)  state_nxt_s = ST_FAULT;
                else if (unlock_s)     state_nxt_s = ST_ACQUIRE;
                else                   state_nxt_s = ST_LOCKED;
            end
            ST_BYPASS: begin
                if (bypass) state_nxt_s = ST_BYPASS;
                else        state_nxt_s = ST_IDLE;
            end
            ST_FAULT: begin
                if (bypass)   state_nxt_s = ST_BYPASS;
                else if (!en) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_FAULT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        in_loop_nxt_s = (state_nxt_s == ST_ACQUIRE) || (state_nxt_s == ST_LOCKED);
    end

    // Code reloads to mid-scale on entry to IDLE and otherwise only moves on a qualified step.
    always_comb begin
        code_nxt_s = dly_code;
        if (state_nxt_s == ST_IDLE) begin
            code_nxt_s = CODE_MID;
        end else if (move_s) begin
            code_nxt_s = sat_code_s;
        end else begin
            code_nxt_s = dly_code;
        end
    end

    // State, loop history counters and all registered outputs.
    always_ff @(posedge CKINP or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            dly_code   <= CODE_MID;
            dll_mode   <= MODE_RST;
            locked     <= 1'b0;
            warning    <= 1'b0;
            fault      <= 1'b0;
            phase_oh   <= {NPHASE{1'b0}};
            wd_cnt_r   <= {WD_W{1'b0}};
            rev_cnt_r  <= {REV_W{1'b0}};
            run_cnt_r  <= {RUN_W{1'b0}};
            have_dir_r <= 1'b0;
            last_dn_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            dly_code <= code_nxt_s;
            warning  <= warn_of(code_nxt_s);
            dll_mode <= mode_of(state_nxt_s);
            locked   <= (state_nxt_s == ST_LOCKED);
            fault    <= (state_nxt_s == ST_FAULT);
            case (state_nxt_s)
                ST_LOCKED: phase_oh <= TAP0 << phase_sel;
                ST_BYPASS: phase_oh <= TAP0;
                default:   phase_oh <= {NPHASE{1'b0}};
            endcase

            if (!in_loop_nxt_s || pd_valid) wd_cnt_r <= {WD_W{1'b0}};
            else                            wd_cnt_r <= wd_cnt_r + WD_ONE;

            if (state_nxt_s != ST_ACQUIRE)
                rev_cnt_r <= {REV_W{1'b0}};
            else if ((state_r == ST_ACQUIRE) && reversal_s && (rev_cnt_r != REV_DONE))
                rev_cnt_r <= rev_cnt_r + REV_ONE;
            else
                rev_cnt_r <= rev_cnt_r;

            if (state_nxt_s != ST_LOCKED)
                run_cnt_r <= {RUN_W{1'b0}};
            else if ((state_r == ST_LOCKED) && move_s)
                run_cnt_r <= run_nxt_s;
            else
                run_cnt_r <= run_cnt_r;

            // Unlock forgets the last direction so re-acquisition starts with no phantom reversal.
            if (!in_loop_nxt_s || unlock_s) begin
                have_dir_r <= 1'b0;
                last_dn_r  <= 1'b0;
            end else if (move_s) begin
                have_dir_r <= 1'b1;
                last_dn_r  <= step_dn_s;
            end else begin
                have_dir_r <= have_dir_r;
                last_dn_r  <= last_dn_r;
            end
        end
    end

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl: lock, saturation, watchdog, unlock,
// bypass/phase select and mid-lock reset scenarios with hand-computed values.
module tb_dll_lock_ctrl;

    logic        CKINP = 1'b0;
    logic        RESET = 1'b0;
    logic        en = 1'b0;
    logic        bypass = 1'b0;
    logic        pd_valid = 1'b0;
    logic        pd_up = 1'b0;
    logic        pd_dn = 1'b0;
    logic [4:0]  phase_sel = 5'd0;
    logic [5:0]  dly_code;
    logic [1:0]  dll_mode;
    logic        locked;
    logic        warning;
    logic        fault;
    logic [31:0] phase_oh;

    int vectors = 0;
    int errors  = 0;

    dll_lock_ctrl dut (
        .CKINP     (CKINP),
        .RESET     (RESET),
        .en        (en),
        .bypass    (bypass),
        .pd_valid  (pd_valid),
        .pd_up     (pd_up),
        .pd_dn     (pd_dn),
        .phase_sel (phase_sel),
        .dly_code  (dly_code),
        .dll_mode  (dll_mode),
        .locked    (locked),
        .warning   (warning),
        .fault     (fault),
        .phase_oh  (phase_oh)
    );

    always #5 CKINP = ~CKINP;

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge CKINP);
            #1;
        end
    endtask

    task automatic strobe(input logic up, input logic dn);
        pd_valid = 1'b1;
        pd_up    = up;
        pd_dn    = dn;
        ticks(1);
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        pd_dn    = 1'b0;
    endtask

    task automatic apply_reset();
        en = 1'b0; bypass = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
        RESET = 1'b1;
        ticks(1);
        RESET = 1'b0;
        ticks(1);
    endtask

    // Enable, then 9 alternating strobes 4 cycles apart: 8 reversals, lock, code 36.
    task automatic go_locked();
        en = 1'b1;
        ticks(1);
        for (int k = 1; k <= 9; k++) begin
            strobe(k % 2 == 1, k % 2 == 0);
            ticks(3);
        end
    endtask

    task automatic test_reset();
        #2;
        RESET = 1'b1;
        #1;
        vectors++; if (dly_code !== 6'd32) begin errors++; $display("FAIL reset_code: got %0d expected %0d", dly_code, 6'd32); end
        vectors++; if (dll_mode !== 2'b10) begin errors++; $display("FAIL reset_mode: got %b expected %b", dll_mode, 2'b10); end
        vectors++; if ({locked, warning, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {locked, warning, fault}, 3'b000); end
        vectors++; if (phase_oh !== 32'h0) begin errors++; $display("FAIL reset_phase: got %h expected %h", phase_oh, 32'h0); end
        ticks(1);
        RESET = 1'b0;
        ticks(3);
        vectors++; if ({dll_mode, dly_code} !== {2'b10, 6'd32}) begin errors++; $display("FAIL idle_hold: got %b/%0d expected 10/32", dll_mode, dly_code); end
    endtask

    task automatic test_lock();
        logic [5:0] exp_code;
        apply_reset();
        en = 1'b1;
        ticks(1);
        vectors++; if ({dll_mode, locked, dly_code} !== {2'b10, 1'b0, 6'd32}) begin errors++; $display("FAIL acq_entry: got %b/%b/%0d expected 10/0/32", dll_mode, locked, dly_code); end
        for (int k = 1; k <= 9; k++) begin
            strobe(k % 2 == 1, k % 2 == 0);
            exp_code = (k % 2 == 1) ? 6'd36 : 6'd32;
            vectors++; if (dly_code !== exp_code) begin errors++; $display("FAIL acq_step%0d: got %0d expected %0d", k, dly_code, exp_code); end
            vectors++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_unlocked%0d: got %b expected %b", k, locked, 1'b0); end
            if (k < 9) ticks(3);
        end
        ticks(1);
        vectors++; if ({locked, dll_mode} !== {1'b1, 2'b00}) begin errors++; $display("FAIL lock_entry: got %b/%b expected 1/00", locked, dll_mode); end
        vectors++; if (dly_code !== 6'd36) begin errors++; $display("FAIL lock_code: got %0d expected %0d", dly_code, 6'd36); end
        ticks(2);
    endtask

    task automatic test_saturation();
        logic [5:0] sat_exp [8];
        sat_exp = '{6'd36, 6'd40, 6'd44, 6'd48, 6'd52, 6'd56, 6'd60, 6'd63};
        apply_reset();
        en = 1'b1;
        ticks(1);
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, 1'b0);
            vectors++; if (dly_code !== sat_exp[i]) begin errors++; $display("FAIL sat_code%0d: got %0d expected %0d", i, dly_code, sat_exp[i]); end
            vectors++; if (warning !== (sat_exp[i] >= 6'd62)) begin errors++; $display("FAIL sat_warn%0d: got %b expected %b", i, warning, sat_exp[i] >= 6'd62); end
            vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL sat_nofault%0d: got %b expected %b", i, fault, 1'b0); end
        end
        strobe(1'b1, 1'b0);
        vectors++; if ({fault, dll_mode, dly_code} !== {1'b1, 2'b10, 6'd63}) begin errors++; $display("FAIL sat_fault: got %b/%b/%0d expected 1/10/63", fault, dll_mode, dly_code); end
        ticks(3);
        vectors++; if ({fault, dly_code} !== {1'b1, 6'd63}) begin errors++; $display("FAIL fault_hold: got %b/%0d expected 1/63", fault, dly_code); end
        en = 1'b0;
        ticks(1);
        vectors++; if ({fault, warning, dly_code} !== {1'b0, 1'b0, 6'd32}) begin errors++; $display("FAIL fault_exit: got %b/%b/%0d expected 0/0/32", fault, warning, dly_code); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        go_locked();
        strobe(1'b1, 1'b0);
        vectors++; if ({locked, dly_code} !== {1'b1, 6'd37}) begin errors++; $display("FAIL wd_fine_step: got %b/%0d expected 1/37", locked, dly_code); end
        ticks(1023);
        vectors++; if ({fault, locked} !== {1'b0, 1'b1}) begin errors++; $display("FAIL wd_early: got %b/%b expected 0/1", fault, locked); end
        ticks(1);
        vectors++; if ({fault, locked, dll_mode} !== {1'b1, 1'b0, 2'b10}) begin errors++; $display("FAIL wd_expire: got %b/%b/%b expected 1/0/10", fault, locked, dll_mode); end
        en = 1'b0;
        ticks(1);
    endtask

    task automatic test_unlock();
        apply_reset();
        go_locked();
        for (int i = 1; i <= 15; i++) strobe(1'b0, 1'b1);
        vectors++; if ({locked, dly_code} !== {1'b1, 6'd21}) begin errors++; $display("FAIL unlock_early: got %b/%0d expected 1/21", locked, dly_code); end
        strobe(1'b0, 1'b1);
        vectors++; if ({locked, dll_mode, dly_code} !== {1'b0, 2'b10, 6'd20}) begin errors++; $display("FAIL unlock_exit: got %b/%b/%0d expected 0/10/20", locked, dll_mode, dly_code); end
        strobe(1'b0, 1'b1);
        vectors++; if (dly_code !== 6'd16) begin errors++; $display("FAIL unlock_coarse: got %0d expected %0d", dly_code, 6'd16); end
        en = 1'b0;
        ticks(1);
    endtask

    task automatic test_bypass_phase();
        apply_reset();
        phase_sel = 5'd0;
        go_locked();
        vectors++; if (phase_oh !== 32'h1) begin errors++; $display("FAIL phase_tap0: got %h expected %h", phase_oh, 32'h1); end
        phase_sel = 5'd5;
        ticks(1);
        vectors++; if ({dll_mode, phase_oh} !== {2'b00, 32'h20}) begin errors++; $display("FAIL phase_sel5: got %b/%h expected 00/00000020", dll_mode, phase_oh); end
        bypass = 1'b1;
        ticks(1);
        vectors++; if ({dll_mode, locked, phase_oh} !== {2'b01, 1'b0, 32'h1}) begin errors++; $display("FAIL bypass_entry: got %b/%b/%h expected 01/0/00000001", dll_mode, locked, phase_oh); end
        vectors++; if (dly_code !== 6'd36) begin errors++; $display("FAIL bypass_code: got %0d expected %0d", dly_code, 6'd36); end
        bypass = 1'b0;
        ticks(1);
        vectors++; if ({dll_mode, phase_oh, dly_code} !== {2'b10, 32'h0, 6'd32}) begin errors++; $display("FAIL bypass_exit: got %b/%h/%0d expected 10/00000000/32", dll_mode, phase_oh, dly_code); end
        en = 1'b0;
        phase_sel = 5'd0;
        ticks(1);
    endtask

    task automatic test_reset_midlock();
        apply_reset();
        go_locked();
        strobe(1'b1, 1'b1);
        vectors++; if ({locked, dly_code} !== {1'b1, 6'd36}) begin errors++; $display("FAIL both_strobe: got %b/%0d expected 1/36", locked, dly_code); end
        strobe(1'b0, 1'b0);
        vectors++; if ({locked, dly_code} !== {1'b1, 6'd36}) begin errors++; $display("FAIL none_strobe: got %b/%0d expected 1/36", locked, dly_code); end
        RESET = 1'b1;
        #1;
        vectors++; if ({dll_mode, locked, warning, fault, dly_code} !== {2'b10, 3'b000, 6'd32}) begin errors++; $display("FAIL async_reset: got %b/%b%b%b/%0d expected 10/000/32", dll_mode, locked, warning, fault, dly_code); end
        vectors++; if (phase_oh !== 32'h0) begin errors++; $display("FAIL async_reset_phase: got %h expected %h", phase_oh, 32'h0); end
        ticks(1);
        RESET = 1'b0;
        ticks(1);
        for (int k = 1; k <= 2; k++) begin
            strobe(k % 2 == 1, k % 2 == 0);
            ticks(3);
        end
        vectors++; if ({locked, dll_mode, dly_code} !== {1'b0, 2'b10, 6'd32}) begin errors++; $display("FAIL relock_history: got %b/%b/%0d expected 0/10/32", locked, dll_mode, dly_code); end
        en = 1'b0;
        ticks(1);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_saturation();
        test_watchdog();
        test_unlock();
        test_bypass_phase();
        test_reset_midlock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
